// File: rtl/vpu_cmd_sequencer.sv
// vpu_cmd_sequencer: CPU->VPU command front end with engine handshake,
// FILL servicing, GETOBJ result writeback and a hang watchdog.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   vpu_start         single-cycle command strobe from the CPU
//   vpu_fill          FILL request level (acted on at its rising edge)
//   vpu_op/code/obj_* held command fields; vpu_vec V7..V0, vpu_ro operand
//   vpu_rdy           idle and no FILL pending
//   eng_req/ack/done  command handshake to the VPU engine
//   eng_*             latched command, stable until the next accepted start
//   eng_result        GETOBJ result, valid with eng_done
//   eng_abort         1-cycle abort on watchdog expiry
//   ro_wr/ro_wdata    1-cycle RO register writeback
//   fill_req/done     handshake to the fill unit
//   err_*             1-cycle error pulses (timeout, illegal op, busy)
module vpu_cmd_sequencer #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vpu_start,
    input  logic         vpu_fill,
    input  logic [3:0]   vpu_op,
    input  logic [3:0]   vpu_code,
    input  logic [1:0]   vpu_obj_type,
    input  logic [2:0]   vpu_obj_color,
    input  logic [4:0]   vpu_obj_num,
    input  logic [127:0] vpu_vec,
    input  logic [15:0]  vpu_ro,
    output logic         vpu_rdy,
    output logic         eng_req,
    output logic [3:0]   eng_op,
    output logic [3:0]   eng_code,
    output logic [1:0]   eng_obj_type,
    output logic [2:0]   eng_color,
    output logic [4:0]   eng_obj_num,
    output logic [127:0] eng_vec,
    output logic [15:0]  eng_ro,
    input  logic         eng_ack,
    input  logic         eng_done,
    input  logic [15:0]  eng_result,
    output logic         eng_abort,
    output logic         ro_wr,
    output logic [15:0]  ro_wdata,
    output logic         fill_req,
    input  logic         fill_done,
    output logic         err_timeout,
    output logic         err_illegal,
    output logic         err_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_WB,
        S_FILL
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       OP_GETOBJ = 4'hF;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wd;
    logic [CNT_W-1:0] wd_nx;
    logic             fill_prev;
    logic             fill_pend;
    logic             fill_pend_nx;
    logic             fill_rise;
    logic             fill_take;
    logic             latch;
    logic             capture;
    logic             illegal_nx;
    logic             busy_nx;
    logic             timeout_nx;
    logic             op_bad;
    logic             finish;

    assign vpu_rdy   = (state == S_IDLE) && !fill_pend;
    assign eng_req   = (state == S_ISSUE);
    assign fill_req  = (state == S_FILL);
    assign ro_wr     = (state == S_WB);
    assign fill_rise = vpu_fill && !fill_prev;
    assign op_bad    = (vpu_op == 4'hD) || (vpu_op == 4'hE);

    // Done only counts in ISSUE when it comes together with ack.
    assign finish = ((state == S_ISSUE) && eng_ack && eng_done)
                 || ((state == S_RUN) && eng_done);

    always_comb begin
        state_nx   = state;
        wd_nx      = wd;
        latch      = 1'b0;
        capture    = 1'b0;
        illegal_nx = 1'b0;
        timeout_nx = 1'b0;
        fill_take  = 1'b0;
        busy_nx    = vpu_start && !vpu_rdy;

        unique case (state)
            S_IDLE: begin
                if (vpu_start && !fill_pend) begin
                    latch = 1'b1;
                    if (op_bad) begin
                        illegal_nx = 1'b1;
                    end else begin
                        state_nx = S_ISSUE;
                        wd_nx    = '0;
                    end
                end else if (fill_pend && !vpu_start) begin
                    fill_take = 1'b1;
                    state_nx  = S_FILL;
                end
            end
            S_ISSUE, S_RUN: begin
                if (finish) begin
                    if (eng_op == OP_GETOBJ) begin
                        capture  = 1'b1;
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (wd == WD_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = S_IDLE;
                end else begin
                    wd_nx = wd + 1'b1;
                    if ((state == S_ISSUE) && eng_ack) begin
                        state_nx = S_RUN;
                    end
                end
            end
            S_WB: begin
                state_nx = S_IDLE;
            end
            S_FILL: begin
                if (fill_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // A new edge during the take cycle must not be lost.
        fill_pend_nx = (fill_pend && !fill_take) || fill_rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wd           <= '0;
            fill_prev    <= 1'b0;
            fill_pend    <= 1'b0;
            eng_op       <= '0;
            eng_code     <= '0;
            eng_obj_type <= '0;
            eng_color    <= '0;
            eng_obj_num  <= '0;
            eng_vec      <= '0;
            eng_ro       <= '0;
            ro_wdata     <= '0;
            eng_abort    <= 1'b0;
            err_timeout  <= 1'b0;
            err_illegal  <= 1'b0;
            err_busy     <= 1'b0;
        end else begin
            state       <= state_nx;
            wd          <= wd_nx;
            fill_prev   <= vpu_fill;
            fill_pend   <= fill_pend_nx;
            eng_abort   <= timeout_nx;
            err_timeout <= timeout_nx;
            err_illegal <= illegal_nx;
            err_busy    <= busy_nx;
            if (latch) begin
                eng_op       <= vpu_op;
                eng_code     <= vpu_code;
                eng_obj_type <= vpu_obj_type;
                eng_color    <= vpu_obj_color;
                eng_obj_num  <= vpu_obj_num;
                eng_vec      <= vpu_vec;
                eng_ro       <= vpu_ro;
            end
            if (capture) begin
                ro_wdata <= eng_result;
            end
        end
    end

endmodule

// File: tb/tb_vpu_cmd_sequencer.sv
// Testbench for vpu_cmd_sequencer: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_vpu_cmd_sequencer;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vpu_start;
    logic         vpu_fill;
    logic [3:0]   vpu_op;
    logic [3:0]   vpu_code;
    logic [1:0]   vpu_obj_type;
    logic [2:0]   vpu_obj_color;
    logic [4:0]   vpu_obj_num;
    logic [127:0] vpu_vec;
    logic [15:0]  vpu_ro;
    logic         vpu_rdy;
    logic         eng_req;
    logic [3:0]   eng_op;
    logic [3:0]   eng_code;
    logic [1:0]   eng_obj_type;
    logic [2:0]   eng_color;
    logic [4:0]   eng_obj_num;
    logic [127:0] eng_vec;
    logic [15:0]  eng_ro;
    logic         eng_ack;
    logic         eng_done;
    logic [15:0]  eng_result;
    logic         eng_abort;
    logic         ro_wr;
    logic [15:0]  ro_wdata;
    logic         fill_req;
    logic         fill_done;
    logic         err_timeout;
    logic         err_illegal;
    logic         err_busy;

    vpu_cmd_sequencer #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .vpu_start(vpu_start), .vpu_fill(vpu_fill),
        .vpu_op(vpu_op), .vpu_code(vpu_code),
        .vpu_obj_type(vpu_obj_type), .vpu_obj_color(vpu_obj_color),
        .vpu_obj_num(vpu_obj_num), .vpu_vec(vpu_vec), .vpu_ro(vpu_ro),
        .vpu_rdy(vpu_rdy), .eng_req(eng_req),
        .eng_op(eng_op), .eng_code(eng_code),
        .eng_obj_type(eng_obj_type), .eng_color(eng_color),
        .eng_obj_num(eng_obj_num), .eng_vec(eng_vec), .eng_ro(eng_ro),
        .eng_ack(eng_ack), .eng_done(eng_done), .eng_result(eng_result),
        .eng_abort(eng_abort), .ro_wr(ro_wr), .ro_wdata(ro_wdata),
        .fill_req(fill_req), .fill_done(fill_done),
        .err_timeout(err_timeout), .err_illegal(err_illegal),
        .err_busy(err_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: what the sequencer is doing, in words.
    // mode 0 idle, 1 waiting for ack, 2 engine running,
    // 3 writing back, 4 filling. age counts cycles the request has lived.
    int           m_mode;
    int           m_age;
    bit           m_pend;
    bit           m_fprev;
    bit           m_abort;
    bit           m_ill;
    bit           m_busy;
    logic [3:0]   m_op;
    logic [3:0]   m_code;
    logic [1:0]   m_type;
    logic [2:0]   m_col;
    logic [4:0]   m_num;
    logic [127:0] m_vec;
    logic [15:0]  m_ro;
    logic [15:0]  m_wdata;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_age   = 0;
        m_pend  = 0;
        m_fprev = 0;
        m_abort = 0;
        m_ill   = 0;
        m_busy  = 0;
        m_op    = '0;
        m_code  = '0;
        m_type  = '0;
        m_col   = '0;
        m_num   = '0;
        m_vec   = '0;
        m_ro    = '0;
        m_wdata = '0;
    endtask

    task automatic model_step();
        bit rise;
        bit take;
        bit fin;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise    = vpu_fill && !m_fprev;
        m_fprev = vpu_fill;
        take    = 0;
        m_abort = 0;
        m_ill   = 0;
        m_busy  = vpu_start && !(m_mode == 0 && !m_pend);
        case (m_mode)
            0: begin
                if (vpu_start && !m_pend) begin
                    m_op   = vpu_op;
                    m_code = vpu_code;
                    m_type = vpu_obj_type;
                    m_col  = vpu_obj_color;
                    m_num  = vpu_obj_num;
                    m_vec  = vpu_vec;
                    m_ro   = vpu_ro;
                    if (vpu_op == 4'hD || vpu_op == 4'hE) begin
                        m_ill = 1;
                    end else begin
                        m_mode = 1;
                        m_age  = 0;
                    end
                end else if (m_pend && !vpu_start) begin
                    m_mode = 4;
                    take   = 1;
                end
            end
            1, 2: begin
                m_age++;
                fin = eng_done && (m_mode == 2 || eng_ack);
                if (fin) begin
                    if (m_op == 4'hF) begin
                        m_mode  = 3;
                        m_wdata = eng_result;
                    end else begin
                        m_mode = 0;
                    end
                end else if (m_age == TO) begin
                    m_abort = 1;
                    m_mode  = 0;
                end else if (m_mode == 1 && eng_ack) begin
                    m_mode = 2;
                end
            end
            3: m_mode = 0;
            4: if (fill_done) m_mode = 0;
            default: m_mode = 0;
        endcase
        m_pend = (m_pend && !take) || rise;
    endtask

    task automatic check_all();
        chk("vpu_rdy", vpu_rdy, (m_mode == 0 && !m_pend));
        chk("eng_req", eng_req, (m_mode == 1));
        chk("fill_req", fill_req, (m_mode == 4));
        chk("ro_wr", ro_wr, (m_mode == 3));
        chk("ro_wdata", ro_wdata, m_wdata);
        chk("eng_abort", eng_abort, m_abort);
        chk("err_timeout", err_timeout, m_abort);
        chk("err_illegal", err_illegal, m_ill);
        chk("err_busy", err_busy, m_busy);
        chk("eng_op", eng_op, m_op);
        chk("eng_code", eng_code, m_code);
        chk("eng_obj_type", eng_obj_type, m_type);
        chk("eng_color", eng_color, m_col);
        chk("eng_obj_num", eng_obj_num, m_num);
        chk("eng_vec", eng_vec, m_vec);
        chk("eng_ro", eng_ro, m_ro);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    int k_abort;
    int req_cnt;

    initial begin
        rst_n         = 1'b0;
        vpu_start     = 1'b0;
        vpu_fill      = 1'b0;
        vpu_op        = '0;
        vpu_code      = '0;
        vpu_obj_type  = '0;
        vpu_obj_color = '0;
        vpu_obj_num   = '0;
        vpu_vec       = '0;
        vpu_ro        = '0;
        eng_ack       = 1'b0;
        eng_done      = 1'b0;
        eng_result    = '0;
        fill_done     = 1'b0;
        model_reset();
        cyc();
        cyc();
        chk("rst_rdy", vpu_rdy, 1'b1);
        chk("rst_vec", eng_vec, 128'h0);
        rst_n = 1'b1;
        cyc();

        // TRAN: ack one cycle after start, done three later
        vpu_op   = 4'h3;
        vpu_code = 4'h2;
        vpu_vec  = {96'h0, 16'h0020, 16'h0010};
        vpu_ro   = 16'h1234;
        vpu_start = 1'b1;
        req_cnt = 0;
        cyc();
        req_cnt += int'(eng_req);
        chk("tran_vec", eng_vec[31:0], 32'h00200010);
        vpu_start = 1'b0;
        eng_ack = 1'b1;
        cyc();
        req_cnt += int'(eng_req);
        eng_ack = 1'b0;
        cyc();
        req_cnt += int'(eng_req);
        cyc();
        req_cnt += int'(eng_req);
        eng_done = 1'b1;
        cyc();
        eng_done = 1'b0;
        chk("tran_req_len", req_cnt, 1);
        chk("tran_rdy", vpu_rdy, 1'b1);
        chk("tran_nowb", ro_wr, 1'b0);
        cyc();

        // GETOBJ: ack and done together
        vpu_op      = 4'hF;
        vpu_obj_num = 5'd7;
        vpu_start   = 1'b1;
        cyc();
        vpu_start  = 1'b0;
        eng_ack    = 1'b1;
        eng_done   = 1'b1;
        eng_result = 16'hBEEF;
        cyc();
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        chk("gob_wr", ro_wr, 1'b1);
        chk("gob_data", ro_wdata, 16'hBEEF);
        chk("gob_busy", vpu_rdy, 1'b0);
        cyc();
        chk("gob_wr_end", ro_wr, 1'b0);
        chk("gob_rdy", vpu_rdy, 1'b1);

        // Timeout: ack, no done
        vpu_op    = 4'h2;
        vpu_start = 1'b1;
        k_abort = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            vpu_start = 1'b0;
            eng_ack = (k == 1);
            if (eng_abort && k_abort == 0) k_abort = k;
            chk("to_nowb", ro_wr, 1'b0);
        end
        eng_ack = 1'b0;
        chk("to_at", k_abort, 9);
        chk("to_idle", vpu_rdy, 1'b1);

        // Fill collides with start
        vpu_op    = 4'h0;
        vpu_start = 1'b1;
        vpu_fill  = 1'b1;
        cyc();
        vpu_start = 1'b0;
        chk("col_rdy0", vpu_rdy, 1'b0);
        chk("col_req", eng_req, 1'b1);
        eng_ack  = 1'b1;
        eng_done = 1'b1;
        cyc();
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        chk("col_rdy1", vpu_rdy, 1'b0);
        chk("col_nofill", fill_req, 1'b0);
        cyc();
        chk("col_fill", fill_req, 1'b1);
        chk("col_rdy2", vpu_rdy, 1'b0);
        cyc();
        chk("col_fill_hold", fill_req, 1'b1);
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        vpu_fill  = 1'b0;
        chk("col_end", vpu_rdy, 1'b1);
        cyc();

        // Illegal op
        vpu_op    = 4'hD;
        vpu_start = 1'b1;
        cyc();
        vpu_start = 1'b0;
        chk("ill_pulse", err_illegal, 1'b1);
        chk("ill_noreq", eng_req, 1'b0);
        chk("ill_rdy", vpu_rdy, 1'b1);
        cyc();

        // Start during RUN, then reset in RUN
        vpu_op    = 4'h1;
        vpu_start = 1'b1;
        cyc();
        vpu_start = 1'b0;
        eng_ack   = 1'b1;
        cyc();
        eng_ack   = 1'b0;
        vpu_op    = 4'h5;
        vpu_start = 1'b1;
        cyc();
        vpu_start = 1'b0;
        chk("busy_pulse", err_busy, 1'b1);
        chk("busy_op", eng_op, 4'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rr_rdy", vpu_rdy, 1'b1);
        chk("rr_op", eng_op, 4'h0);
        chk("rr_abort", eng_abort, 1'b0);
        cyc();
        chk("rr_abort2", eng_abort, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(199) != 0);
            vpu_start     = ($urandom_range(3) == 0);
            vpu_op        = 4'($urandom());
            vpu_code      = 4'($urandom());
            vpu_obj_type  = 2'($urandom());
            vpu_obj_color = 3'($urandom());
            vpu_obj_num   = 5'($urandom());
            vpu_vec       = {$urandom(), $urandom(), $urandom(), $urandom()};
            vpu_ro        = 16'($urandom());
            eng_ack       = ($urandom_range(1) == 0);
            eng_done      = ($urandom_range(3) == 0);
            eng_result    = 16'($urandom());
            fill_done     = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0) vpu_fill = ~vpu_fill;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vpu_cmd_sequencer.md
# vpu_cmd_sequencer

VPU-side command front end for the CPU→VPU interface. It captures the single-cycle start strobe and the held command fields and vector operands, deasserts `vpu_rdy` while busy, and issues the command to the VPU engine over a req/ack/done handshake. It services FILL requests separately and writes the GETOBJ result back into the RO register path. A watchdog aborts commands that hang.

## Interface
- `TIMEOUT`, default 4096: number of cycles in ISSUE+RUN before the command is aborted.
- `CNT_W`, default 16: watchdog counter width. Requires `TIMEOUT < 2^CNT_W`.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `vpu_start`  in  1  single-cycle command strobe from CPU
- `vpu_fill`  in  1  FILL request level; acted on at its rising edge
- `vpu_op`  in  4  operation code: 0–C valid, F = GETOBJ, D/E illegal
- `vpu_code`  in  4  operation modifier
- `vpu_obj_type`  in  2  object type
- `vpu_obj_color`  in  3  object color
- `vpu_obj_num`  in  5  object number
- `vpu_vec`  in  128  V7..V0, 16 b each, V0 in [15:0]
- `vpu_ro`  in  16  RO operand
- `vpu_rdy`  out  1  idle, ready to accept a command
- `eng_req`  out  1  command valid to engine
- `eng_op`, `eng_code`, `eng_obj_type`, `eng_color`, `eng_obj_num`, `eng_vec`, `eng_ro`  out  4/4/2/3/5/128/16  latched command
- `eng_ack`  in  1  engine accepted request
- `eng_done`  in  1  engine finished; `eng_result` valid
- `eng_result`  in  16  GETOBJ result
- `eng_abort`  out  1  1-cycle abort on timeout
- `ro_wr`  out  1  1-cycle RO writeback strobe
- `ro_wdata`  out  16  writeback data
- `fill_req`  out  1  FILL request to fill unit
- `fill_done`  in  1  fill unit finished
- `err_timeout`, `err_illegal`, `err_busy`  out  1  1-cycle error pulses

## Operation
- States: IDLE, ISSUE, RUN, WB, FILL.
- `vpu_rdy = (state==IDLE) && !fill_pend`. It is combinational from state.
- IDLE with `vpu_start=1`:
  - Latch all command fields, `vpu_vec` and `vpu_ro` into the `eng_*` registers.
  - Op D/E: pulse `err_illegal`, stay IDLE, no request issued.
  - Otherwise go to ISSUE and clear the watchdog.
- ISSUE: `eng_req=1`. On `eng_ack`:
  - If `eng_done` is also set, finish (see RUN).
  - Otherwise go to RUN.
- RUN: on `eng_done`, go to WB if `eng_op==F`, else to IDLE.
- WB: `ro_wr=1` and `ro_wdata=eng_result` (captured at done) for one cycle, then IDLE.
- Watchdog: increments every cycle in ISSUE/RUN. When the count reaches `TIMEOUT-1` with no done:
  - Pulse `eng_abort` and `err_timeout`.
  - Go to IDLE with no writeback.
- FILL requests:
  - A rising edge of `vpu_fill` (registered previous value) sets `fill_pend`.
  - From IDLE with `fill_pend` and no `vpu_start`: go to FILL, clear `fill_pend`.
  - FILL: `fill_req=1` until `fill_done`, then IDLE.
- Simultaneous `vpu_start` and fill edge in IDLE: the command wins and `fill_pend` is serviced afterwards.
- `vpu_start` while not IDLE, or while `fill_pend` is set: ignored, `err_busy` pulses.
- `eng_*` outputs hold stable from latch until the next accepted start.
- `eng_done` outside ISSUE/RUN is ignored. `fill_done` outside FILL is ignored.
- Reset values:
  - state IDLE, `vpu_rdy=1`.
  - All `eng_*`, `ro_*`, `fill_req`, `err_*`, `eng_abort`, `fill_pend` = 0.
  - Watchdog = 0. Registered `vpu_fill` = 0.
- Reset mid-operation: returns to IDLE. No abort or writeback pulse is generated.

## Timing
- `vpu_start` sampled at edge T: `eng_req=1` and `vpu_rdy=0` from T+1.
- `eng_ack` sampled at edge A: `eng_req=0` from A+1.
- `eng_done` at edge D:
  - Non-GETOBJ: `vpu_rdy=1` from D+1.
  - GETOBJ: `ro_wr` high during D+1, `vpu_rdy=1` from D+2.
- Minimum command turnaround is 2 cycles (ack+done in the first ISSUE cycle).
- Fill edge at IDLE edge F: `fill_req=1` from F+2. There is one cycle of pend latency; `vpu_rdy=0` from F+1.
- Timeout: abort pulse in the cycle after the edge where count = `TIMEOUT-1`. Total request lifetime is `TIMEOUT` cycles.

## Test plan
- TRAN: op=3, V0=0x0010, V1=0x0020. Start, ack at +1, done at +4.
  - Expect `eng_req` for 1 cycle and `eng_vec[31:0]=0x00200010`.
  - Expect no `ro_wr` and `vpu_rdy` back at done+1.
- GETOBJ: op=F, obj_num=7. Ack and done in the same cycle, `eng_result=0xBEEF`.
  - Expect `ro_wr=1` with `ro_wdata=0xBEEF` for exactly one cycle, then `vpu_rdy=1`.
- Timeout: `TIMEOUT=8`, ack given, no done.
  - Expect `eng_abort` and `err_timeout` pulses 8 cycles after `eng_req` rises, then IDLE with no `ro_wr`.
- Fill collision: `vpu_fill` rises in the same cycle as `vpu_start` (op=0).
  - Expect the command to complete first, then `fill_req=1` until `fill_done`.
  - Expect `vpu_rdy=0` throughout.
- Errors:
  - op=D start: expect `err_illegal` pulse, no `eng_req`, `vpu_rdy` stays 1.
  - Start during RUN: expect `err_busy` pulse and `eng_op` unchanged.
- Reset asserted in RUN: expect IDLE, `vpu_rdy=1`, all `eng_*` = 0, no abort pulse.
